// File: rtl/mem_copy_dma.sv
// Copy engine for the single-port SRAM: moves LEN words from SRC to DST,
// one read then one write per word, and accumulates a checksum of the words read.
module mem_copy_dma #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic [DATA_W-1:0] csum,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_cs_,
   output logic              mem_rw_
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

   localparam logic [ADDR_W-1:0] A_ONE = 1;
   localparam logic [ADDR_W:0]   C_ONE = 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] csum_q, csum_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_rw_q, mem_rw_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] i_inc;
   logic [ADDR_W:0]   count_inc;

   assign i_inc     = i_q + A_ONE;
   assign count_inc = count_q + C_ONE;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      i_d         = i_q;
      count_d     = count_q;
      csum_d      = csum_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_cs_d    = 1'b1;
      mem_rw_d    = 1'b1;
      // done lands the cycle after FIN so start-to-done is 2*len+1 cycles
      done_d      = (state_q == S_FIN);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d   = src;
               dst_d   = dst;
               len_d   = len;
               count_d = '0;
               csum_d  = '0;
               i_d     = '0;
               if (len == '0) begin
                  state_d = S_FIN;
               end else begin
                  state_d    = S_RD;
                  mem_addr_d = src;
                  mem_cs_d   = 1'b0;
               end
            end
         end
         S_RD: begin
            if (abort) begin
               state_d = S_FIN;
            end else begin
               mem_wdata_d = mem_rdata;
               csum_d      = csum_q + mem_rdata;
               state_d     = S_WR;
               mem_addr_d  = dst_q + i_q;
               mem_cs_d    = 1'b0;
               mem_rw_d    = 1'b0;
            end
         end
         S_WR: begin
            count_d = count_inc;
            i_d     = i_inc;
            if ((count_inc == len_q) || abort) begin
               state_d = S_FIN;
            end else begin
               state_d    = S_RD;
               mem_addr_d = src_q + i_inc;
               mem_cs_d   = 1'b0;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy also covers the done cycle so the two are seen together
      busy_d = (state_d != S_IDLE) || (state_q == S_FIN);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         i_q         <= '0;
         count_q     <= '0;
         csum_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_cs_q    <= 1'b1;
         mem_rw_q    <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         i_q         <= i_d;
         count_q     <= count_d;
         csum_q      <= csum_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_cs_q    <= mem_cs_d;
         mem_rw_q    <= mem_rw_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
   assign csum      = csum_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_cs_   = mem_cs_q;
   assign mem_rw_   = mem_rw_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: a behavioural SRAM plus a forward-copy
// reference model that queues the expected bus sequence for each copy.
module tb_mem_copy_dma;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int NW = 1 << AW;

   typedef struct {
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } bus_t;

   logic          clk = 1'b0;
   logic          rst_;
   logic          start;
   logic [AW-1:0] src, dst;
   logic [AW:0]   len;
   logic          abort;
   logic          busy, done;
   logic [AW:0]   count;
   logic [DW-1:0] csum;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_cs_, mem_rw_;

   logic [DW-1:0] mem  [NW];
   logic [DW-1:0] refm [NW];
   logic          fill, poke;
   logic [AW-1:0] poke_a;
   logic [DW-1:0] poke_d;
   logic [DW-1:0] fill_seed;

   bus_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_(rst_), .start(start), .src(src), .dst(dst), .len(len),
      .abort(abort), .busy(busy), .done(done), .count(count), .csum(csum),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_cs_(mem_cs_), .mem_rw_(mem_rw_)
   );

   // Behavioural SRAM: combinational read, write on the edge ending a write cycle
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (fill) begin
         for (int a = 0; a < NW; a++) mem[a] <= fill_seed ^ (32'(a) * 32'h0001_0003);
      end else if (poke) begin
         mem[poke_a] <= poke_d;
      end else if (!mem_cs_ && !mem_rw_) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Every enabled bus cycle must match the next queued access
   always @(negedge clk) begin
      if (rst_ === 1'b1 && mem_cs_ === 1'b0) begin
         if (exp_q.size() == 0) begin
            check("bus_extra", {mem_rw_, mem_addr}, 64'hFFFF_FFFF);
         end else begin
            bus_t e;
            e = exp_q.pop_front();
            check("bus_rw", mem_rw_, e.rw);
            check("bus_addr", mem_addr, e.addr);
            if (!e.rw) check("bus_wdata", mem_wdata, e.data);
         end
      end
   end

   task automatic do_fill(input logic [DW-1:0] seed);
      @(negedge clk);
      fill_seed = seed;
      fill = 1'b1;
      @(negedge clk);
      fill = 1'b0;
   endtask

   task automatic do_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      poke = 1'b1;
      poke_a = a;
      poke_d = d;
      @(negedge clk);
      poke = 1'b0;
   endtask

   // Forward word-by-word copy on the reference image; queues the bus accesses
   task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int nw,
                        output logic [DW-1:0] sum);
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] v;
      for (int a = 0; a < NW; a++) refm[a] = mem[a];
      sum = '0;
      for (int k = 0; k < nw; k++) begin
         ra = s + AW'(k);
         wa = d + AW'(k);
         v  = refm[ra];
         exp_q.push_back('{rw: 1'b1, addr: ra, data: '0});
         exp_q.push_back('{rw: 1'b0, addr: wa, data: v});
         refm[wa] = v;
         sum += v;
      end
   endtask

   task automatic check_image(input string tag);
      int nbad = 0;
      for (int a = 0; a < NW; a++) if (mem[a] !== refm[a]) nbad++;
      check(tag, nbad, 0);
   endtask

   task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n, input int abort_at, input int nw,
                           input int exp_lat);
      logic [DW-1:0] sum;
      int cyc = 0;
      bit got = 1'b0;
      model(s, d, nw, sum);
      @(negedge clk);
      start = 1'b1;
      src = s;
      dst = d;
      len = n;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 200 && !got) begin
         @(negedge clk);
         cyc++;
         abort = (cyc == abort_at);
         if (done) got = 1'b1;
      end
      abort = 1'b0;
      check({tag, "_done_seen"}, got, 1);
      check({tag, "_done_lat"}, cyc, exp_lat);
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_count"}, count, nw);
      check({tag, "_csum"}, csum, sum);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_count_hold"}, count, nw);
      check({tag, "_bus_left"}, exp_q.size(), 0);
      check_image({tag, "_mem"});
   endtask

   initial begin
      logic [DW-1:0] sum, o3fe, o3ff;
      logic [AW-1:0] rs, rd;
      int bad;
      rst_ = 1'b0; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
      fill = 1'b0; poke = 1'b0; poke_a = '0; poke_d = '0; fill_seed = '0;
      #12;
      check("rst_cs", mem_cs_, 1);
      check("rst_rw", mem_rw_, 1);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_csum", csum, 0);
      @(negedge clk);
      rst_ = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (mem_cs_ !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
             count !== '0 || csum !== '0) bad++;
      end
      check("idle_quiet", bad, 0);

      do_fill(32'h5A00_0000);
      for (int k = 0; k < 4; k++) do_poke(AW'(10'h10 + k), DW'(k + 1));
      run_copy("basic", 10'h010, 10'h040, 11'd4, -1, 4, 9);
      check("basic_csum10", csum, 10);
      check("basic_w43", mem[10'h043], 4);

      run_copy("zero", 10'h020, 10'h060, 11'd0, -1, 0, 1);

      o3fe = mem[10'h3FE];
      o3ff = mem[10'h3FF];
      run_copy("wrap", 10'h3FE, 10'h000, 11'd4, -1, 4, 9);
      check("wrap_m2", mem[10'h002], o3fe);
      check("wrap_m3", mem[10'h003], o3ff);

      run_copy("abort", 10'h100, 10'h200, 11'd8, 5, 3, 7);

      run_copy("overlap", 10'h300, 10'h302, 11'd6, -1, 6, 13);

      for (int t = 0; t < 3; t++) begin
         rs = AW'($urandom_range(0, NW - 1));
         rd = AW'($urandom_range(0, NW - 1));
         run_copy("rand", rs, rd, 11'd5, -1, 5, 11);
      end

      // Reset dropped part-way through the second write cycle
      model(10'h080, 10'h0C0, 1, sum);
      exp_q.push_back('{rw: 1'b1, addr: 10'h081, data: '0});
      @(negedge clk);
      start = 1'b1; src = 10'h080; dst = 10'h0C0; len = 11'd4;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_ = 1'b0;
      #1;
      check("arst_cs", mem_cs_, 1);
      check("arst_rw", mem_rw_, 1);
      check("arst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      check("arst_count", count, 0);
      check("arst_csum", csum, 0);
      check("arst_bus_left", exp_q.size(), 0);
      check_image("arst_mem");
      run_copy("after_rst", 10'h080, 10'h0C0, 11'd4, -1, 4, 9);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
